// File: rtl/spiflash_reader.sv
// SPI flash READ (0x03) sequencer: drives SS/SCK/MOSI in mode 0 from a clk divider,
// shifts 24-bit address out and streams len bytes back on a data/data_valid strobe.
module spiflash_reader #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        spi_ss,
    output logic        spi_sck,
    input  logic        spi_miso,
    output logic        spi_mosi
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, GAP, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [7:0] READ_CMD = 8'h03;

    state_t      state, state_n;
    logic [7:0]  div_cnt, div_cnt_n;
    logic [7:0]  gap_cnt, gap_cnt_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [31:0] tx, tx_n;
    logic [7:0]  rx, rx_n;
    logic [15:0] byte_cnt, byte_cnt_n;
    logic        byte_ready, byte_ready_n;
    logic        busy_n, done_n, data_valid_n, ss_n, sck_n, mosi_n;
    logic [7:0]  data_n;
    logic        half_end, enter_gap;

    // Every output is a flop; the comb block below only computes next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            rx         <= '0;
            byte_cnt   <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            spi_ss     <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            gap_cnt    <= gap_cnt_n;
            bit_cnt    <= bit_cnt_n;
            tx         <= tx_n;
            rx         <= rx_n;
            byte_cnt   <= byte_cnt_n;
            byte_ready <= byte_ready_n;
            busy       <= busy_n;
            done       <= done_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            spi_ss     <= ss_n;
            spi_sck    <= sck_n;
            spi_mosi   <= mosi_n;
        end
    end

    assign half_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_n      = state;
        div_cnt_n    = div_cnt;
        gap_cnt_n    = gap_cnt;
        bit_cnt_n    = bit_cnt;
        tx_n         = tx;
        rx_n         = rx;
        byte_cnt_n   = byte_cnt;
        byte_ready_n = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;
        data_n       = data;
        data_valid_n = 1'b0;
        ss_n         = spi_ss;
        sck_n        = spi_sck;
        mosi_n       = spi_mosi;
        enter_gap    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = CMD;
                    busy_n     = 1'b1;
                    ss_n       = 1'b0;
                    sck_n      = 1'b0;
                    tx_n       = {READ_CMD, addr};
                    mosi_n     = READ_CMD[7];
                    byte_cnt_n = len;
                    div_cnt_n  = '0;
                    bit_cnt_n  = '0;
                end
            end
            CMD, ADDR, READ: begin
                if (abort) begin
                    enter_gap = 1'b1;
                end else begin
                    div_cnt_n = half_end ? 8'd0 : div_cnt + 8'd1;
                    // The strobe trails the 8th sampling edge by one clk.
                    if (byte_ready) begin
                        data_valid_n = 1'b1;
                        data_n       = rx;
                    end
                    if (half_end && !spi_sck) begin
                        sck_n = 1'b1;
                        if (state == READ) begin
                            rx_n = {rx[6:0], spi_miso};
                            if (bit_cnt == 5'd7) begin
                                byte_ready_n = 1'b1;
                                byte_cnt_n   = byte_cnt - 16'd1;
                            end
                        end
                    end else if (half_end) begin
                        sck_n = 1'b0;
                        case (state)
                            READ: begin
                                if (bit_cnt == 5'd7) begin
                                    bit_cnt_n = '0;
                                    enter_gap = (byte_cnt == 16'd0);
                                end else begin
                                    bit_cnt_n = bit_cnt + 5'd1;
                                end
                            end
                            ADDR: begin
                                if (bit_cnt == 5'd23) begin
                                    bit_cnt_n = '0;
                                    mosi_n    = 1'b0;
                                    if (byte_cnt == 16'd0) enter_gap = 1'b1;
                                    else state_n = READ;
                                end else begin
                                    bit_cnt_n = bit_cnt + 5'd1;
                                    mosi_n    = tx[30];
                                    tx_n      = {tx[30:0], 1'b0};
                                end
                            end
                            default: begin
                                bit_cnt_n = (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                                if (bit_cnt == 5'd7) state_n = ADDR;
                                mosi_n = tx[30];
                                tx_n   = {tx[30:0], 1'b0};
                            end
                        endcase
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        // Abort and normal completion share the same bus release into GAP.
        if (enter_gap) begin
            state_n   = GAP;
            ss_n      = 1'b1;
            sck_n     = 1'b0;
            mosi_n    = 1'b0;
            gap_cnt_n = '0;
            div_cnt_n = '0;
        end
    end
endmodule
